// File: rtl/car_wipe_accum_pkg.sv
// Shared B1 receive-channel widths and the saturating add used by the carrier-wipe accumulators.
package car_wipe_accum_pkg;

    localparam int B1_ADC_WIDTH = 4;
    localparam int B1_CAR_WIDTH = 8;
    localparam int B1_ACC_WIDTH = 24;
    localparam int B1_CNT_WIDTH = 16;

    // Operands must already lie inside the w-bit signed range; the result is clamped to that range.
    function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                   input logic signed [63:0] b,
                                                   input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        logic signed [63:0] s;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        s  = a + b;
        if (s > hi) return hi;
        if (s < lo) return lo;
        return s;
    endfunction

endpackage

// File: rtl/car_wipe_accum_if.sv
// Sample/carrier input and I/Q integral result bundle between the NCO side, the accumulator and the loop.
interface car_wipe_accum_if import car_wipe_accum_pkg::*; #(
  parameter int ADC_WIDTH = B1_ADC_WIDTH,
  parameter int CAR_WIDTH = B1_CAR_WIDTH,
  parameter int ACC_WIDTH = B1_ACC_WIDTH,
  parameter int CNT_WIDTH = B1_CNT_WIDTH
) ();
  logic signed [ADC_WIDTH-1:0] rx_adc_data;
  logic                        rx_adc_valid;
  logic signed [CAR_WIDTH-1:0] rx_car_cos;
  logic signed [CAR_WIDTH-1:0] rx_car_sin;
  logic                        rx_dump;
  logic                        rx_acc_ready;
  logic signed [ACC_WIDTH-1:0] tx_acc_i;
  logic signed [ACC_WIDTH-1:0] tx_acc_q;
  logic [CNT_WIDTH-1:0]        tx_acc_cnt;
  logic                        tx_acc_sat;
  logic                        tx_acc_valid;
  logic                        tx_ovf;

  modport master (
    output rx_adc_data, rx_adc_valid, rx_car_cos, rx_car_sin, rx_dump, rx_acc_ready,
    input  tx_acc_i, tx_acc_q, tx_acc_cnt, tx_acc_sat, tx_acc_valid, tx_ovf
  );

  modport slave (
    input  rx_adc_data, rx_adc_valid, rx_car_cos, rx_car_sin, rx_dump, rx_acc_ready,
    output tx_acc_i, tx_acc_q, tx_acc_cnt, tx_acc_sat, tx_acc_valid, tx_ovf
  );
endinterface

// File: rtl/car_wipe_accum_iq_acc_lane.sv
// One carrier-wipe lane: registered adc*carrier product, saturating integrator and sticky saturation flag.
// fin_o/fin_sat_o are the period totals including the current stage-1 sample, ready for a dump.
module iq_acc_lane import car_wipe_accum_pkg::*; #(
  parameter int ADC_WIDTH = B1_ADC_WIDTH,
  parameter int CAR_WIDTH = B1_CAR_WIDTH,
  parameter int ACC_WIDTH = B1_ACC_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic signed [ADC_WIDTH-1:0] adc_i,
  input  logic signed [CAR_WIDTH-1:0] car_i,
  input  logic                        vld_i,
  input  logic                        dump_i,
  output logic signed [ACC_WIDTH-1:0] fin_o,
  output logic                        fin_sat_o
);
  localparam int PW = ADC_WIDTH + CAR_WIDTH;

  logic signed [PW-1:0]        p_q, p_d;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                        sat_q, sat_d;
  logic signed [63:0]          addend, raw, clamped;
  logic                        ovf;

  always_comb begin
    p_d       = PW'(adc_i) * PW'(car_i);
    addend    = vld_i ? 64'(p_q) : 64'sd0;
    raw       = 64'(acc_q) + addend;
    clamped   = sat_add(64'(acc_q), addend, ACC_WIDTH);
    ovf       = (clamped != raw);
    fin_o     = clamped[ACC_WIDTH-1:0];
    fin_sat_o = sat_q | ovf;
    // A dump hands the totals out and restarts the period from zero in the same cycle.
    acc_d     = dump_i ? '0 : fin_o;
    sat_d     = dump_i ? 1'b0 : fin_sat_o;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q   <= '0;
      acc_q <= '0;
      sat_q <= 1'b0;
    end else begin
      p_q   <= p_d;
      acc_q <= acc_d;
      sat_q <= sat_d;
    end
  end
endmodule

// File: rtl/car_wipe_accum.sv
// Carrier wipe-off and I/Q integrate-and-dump; result held on valid/ready, overwritten (with tx_ovf) if unread.
// Sample+dump at cycle t gives tx_acc_valid at t+2.
module car_wipe_accum import car_wipe_accum_pkg::*; #(
  parameter int ADC_WIDTH = B1_ADC_WIDTH,
  parameter int CAR_WIDTH = B1_CAR_WIDTH,
  parameter int ACC_WIDTH = B1_ACC_WIDTH,
  parameter int CNT_WIDTH = B1_CNT_WIDTH
) (
  input  logic              rx_clk,
  input  logic              rx_rst_n,
  car_wipe_accum_if.slave   bus
);
  logic                        v1_q, d1_q;
  logic signed [ACC_WIDTH-1:0] fin_i, fin_q;
  logic                        fin_sat_i, fin_sat_q;
  logic [CNT_WIDTH-1:0]        cnt_q, cnt_d, cnt_fin;
  logic signed [ACC_WIDTH-1:0] res_i_q, res_i_d, res_q_q, res_q_d;
  logic [CNT_WIDTH-1:0]        res_cnt_q, res_cnt_d;
  logic                        res_sat_q, res_sat_d;
  logic                        vld_q, vld_d, ovf_q, ovf_d;

  iq_acc_lane #(.ADC_WIDTH(ADC_WIDTH), .CAR_WIDTH(CAR_WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_lane_i (
    .clk(rx_clk), .rst_n(rx_rst_n), .adc_i(bus.rx_adc_data), .car_i(bus.rx_car_cos),
    .vld_i(v1_q), .dump_i(d1_q), .fin_o(fin_i), .fin_sat_o(fin_sat_i)
  );

  iq_acc_lane #(.ADC_WIDTH(ADC_WIDTH), .CAR_WIDTH(CAR_WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_lane_q (
    .clk(rx_clk), .rst_n(rx_rst_n), .adc_i(bus.rx_adc_data), .car_i(bus.rx_car_sin),
    .vld_i(v1_q), .dump_i(d1_q), .fin_o(fin_q), .fin_sat_o(fin_sat_q)
  );

  always_comb begin
    // Counter sticks at all-ones rather than wrapping on very long periods.
    cnt_fin   = (v1_q && (cnt_q != '1)) ? cnt_q + CNT_WIDTH'(1) : cnt_q;
    cnt_d     = d1_q ? '0 : cnt_fin;
    res_i_d   = res_i_q;
    res_q_d   = res_q_q;
    res_cnt_d = res_cnt_q;
    res_sat_d = res_sat_q;
    vld_d     = vld_q & ~bus.rx_acc_ready;
    ovf_d     = 1'b0;
    if (d1_q) begin
      res_i_d   = fin_i;
      res_q_d   = fin_q;
      res_cnt_d = cnt_fin;
      res_sat_d = fin_sat_i | fin_sat_q;
      vld_d     = 1'b1;
      ovf_d     = vld_q & ~bus.rx_acc_ready;
    end
  end

  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      v1_q      <= 1'b0;
      d1_q      <= 1'b0;
      cnt_q     <= '0;
      res_i_q   <= '0;
      res_q_q   <= '0;
      res_cnt_q <= '0;
      res_sat_q <= 1'b0;
      vld_q     <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      v1_q      <= bus.rx_adc_valid;
      d1_q      <= bus.rx_dump;
      cnt_q     <= cnt_d;
      res_i_q   <= res_i_d;
      res_q_q   <= res_q_d;
      res_cnt_q <= res_cnt_d;
      res_sat_q <= res_sat_d;
      vld_q     <= vld_d;
      ovf_q     <= ovf_d;
    end
  end

  assign bus.tx_acc_i     = res_i_q;
  assign bus.tx_acc_q     = res_q_q;
  assign bus.tx_acc_cnt   = res_cnt_q;
  assign bus.tx_acc_sat   = res_sat_q;
  assign bus.tx_acc_valid = vld_q;
  assign bus.tx_ovf       = ovf_q;
endmodule
